// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Shares one iterative CORDIC angle engine between two I/Q requesters.
//   A round-robin pointer picks which requester is served next. The block
//   captures that requester's operands, pulses the engine start and then
//   waits for the engine's done pulse. The resulting angle is returned on a
//   valid/ready port, tagged with the requester id. A watchdog aborts a job
//   if the engine stays silent for too long, so a hung engine cannot lock
//   the receiver.
//
// Ports
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   req0_valid/_I/_Q/_ready  requester 0 operand handshake
//   req1_valid/_I/_Q/_ready  requester 1 operand handshake
//   cordic_start             one-cycle engine start pulse
//   cordic_I/_Q              engine operands, held from start to done
//   cordic_done              engine result strobe
//   cordic_angle             engine result angle
//   res_valid/_id/_angle     result port, held until res_ready
//   res_ready                consumer accepts the result
//   timeout_err              one-cycle pulse when the watchdog aborts a job

module cordic_arbiter #(
    parameter int DATA_W  = 4,
    parameter int ANGLE_W = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0_valid,
    input  logic [DATA_W-1:0]  req0_I,
    input  logic [DATA_W-1:0]  req0_Q,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [DATA_W-1:0]  req1_I,
    input  logic [DATA_W-1:0]  req1_Q,
    output logic               req1_ready,
    output logic               cordic_start,
    output logic [DATA_W-1:0]  cordic_I,
    output logic [DATA_W-1:0]  cordic_Q,
    input  logic               cordic_done,
    input  logic [ANGLE_W-1:0] cordic_angle,
    output logic               res_valid,
    output logic               res_id,
    output logic [ANGLE_W-1:0] res_angle,
    input  logic               res_ready,
    output logic               timeout_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic            rr;
    logic            job_id;
    logic [WD_W-1:0] watchdog;

    logic rr_valid;
    logic other_valid;
    logic grant;
    logic grant_valid;
    logic accept;
    logic wd_expired;

    // The requester named by rr has priority; the other one is served only
    // when the priority requester is idle. Ready is gated by reset_n so
    // that every output reads zero while reset is held.
    always_comb begin
        rr_valid    = rr ? req1_valid : req0_valid;
        other_valid = rr ? req0_valid : req1_valid;
        grant       = rr_valid ? rr : ~rr;
        grant_valid = rr_valid | other_valid;
        accept      = reset_n && (state == IDLE) && grant_valid;
        req0_ready  = accept && !grant;
        req1_ready  = accept && grant;
    end

    // The timeout does not fire when done arrives in the same cycle, so a
    // result that just makes the deadline is still delivered.
    always_comb begin
        wd_expired   = (watchdog == WD_LAST);
        cordic_start = (state == ISSUE);
        timeout_err  = (state == WAIT) && !cordic_done && wd_expired;
    end

    // Job sequencing. A done pulse is only looked at in WAIT, so a late or
    // stray done after an abort or reset cannot create a result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            job_id    <= 1'b0;
            watchdog  <= '0;
            cordic_I  <= '0;
            cordic_Q  <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_angle <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cordic_I <= grant ? req1_I : req0_I;
                        cordic_Q <= grant ? req1_Q : req0_Q;
                        job_id   <= grant;
                        rr       <= ~grant;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cordic_done) begin
                        res_angle <= cordic_angle;
                        res_id    <= job_id;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else if (wd_expired) begin
                        state <= IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter
//   Directed bench for cordic_arbiter. The engine is played by hand from the
//   stimulus sequence, and every expected value is written out as a constant.
//
// Ports
//   none (top-level bench)

module tb_cordic_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0_valid;
    logic [3:0]  req0_I;
    logic [3:0]  req0_Q;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_I;
    logic [3:0]  req1_Q;
    logic        req1_ready;
    logic        cordic_start;
    logic [3:0]  cordic_I;
    logic [3:0]  cordic_Q;
    logic        cordic_done;
    logic [15:0] cordic_angle;
    logic        res_valid;
    logic        res_id;
    logic [15:0] res_angle;
    logic        res_ready;
    logic        timeout_err;

    int checks;
    int failures;

    cordic_arbiter #(.DATA_W(4), .ANGLE_W(16), .TIMEOUT(64)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req0_valid   (req0_valid),
        .req0_I       (req0_I),
        .req0_Q       (req0_Q),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_I       (req1_I),
        .req1_Q       (req1_Q),
        .req1_ready   (req1_ready),
        .cordic_start (cordic_start),
        .cordic_I     (cordic_I),
        .cordic_Q     (cordic_Q),
        .cordic_done  (cordic_done),
        .cordic_angle (cordic_angle),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_angle    (res_angle),
        .res_ready    (res_ready),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Every output must read zero while reset is held.
    task automatic check_all_zero(input string tag);
        check({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
        check({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
        check({tag, "_start"},      32'(cordic_start), 32'd0);
        check({tag, "_cordic_I"},   32'(cordic_I), 32'd0);
        check({tag, "_cordic_Q"},   32'(cordic_Q), 32'd0);
        check({tag, "_res_valid"},  32'(res_valid), 32'd0);
        check({tag, "_res_id"},     32'(res_id), 32'd0);
        check({tag, "_res_angle"},  32'(res_angle), 32'd0);
        check({tag, "_timeout"},    32'(timeout_err), 32'd0);
    endtask

    initial begin
        logic        early;
        logic        g;
        logic [3:0]  exp_i;
        logic [3:0]  exp_q;

        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        req0_valid   = 1'b0;
        req0_I       = '0;
        req0_Q       = '0;
        req1_valid   = 1'b0;
        req1_I       = '0;
        req1_Q       = '0;
        cordic_done  = 1'b0;
        cordic_angle = '0;
        res_ready    = 1'b0;

        // Reset state, with requests pending while reset is held.
        #2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_all_zero("rst0");
        step();
        reset_n    = 1'b1;
        req1_valid = 1'b0;
        #1;
        check("rel_req0_ready", 32'(req0_ready), 32'd1);
        check("rel_req1_ready", 32'(req1_ready), 32'd0);

        // Single job from requester 0; engine answers 10 cycles after start.
        req0_I = 4'd3;
        req0_Q = 4'd5;
        #1;
        step();
        req0_valid = 1'b0;
        #1;
        check("j1_start",    32'(cordic_start), 32'd1);
        check("j1_cordic_I", 32'(cordic_I), 32'd3);
        check("j1_cordic_Q", 32'(cordic_Q), 32'd5);
        check("j1_ready0",   32'(req0_ready), 32'd0);
        step();
        check("j1_start_low", 32'(cordic_start), 32'd0);
        for (int k = 0; k < 9; k++) step();
        cordic_done  = 1'b1;
        cordic_angle = 16'd59;
        #1;
        check("j1_no_res_yet", 32'(res_valid), 32'd0);
        step();
        cordic_done  = 1'b0;
        cordic_angle = 16'd999;
        req1_valid   = 1'b1;
        #1;
        check("j1_res_valid", 32'(res_valid), 32'd1);
        check("j1_res_id",    32'(res_id), 32'd0);
        check("j1_res_angle", 32'(res_angle), 32'd59);

        // Back-pressure: result held, no request accepted, done ignored.
        for (int k = 0; k < 5; k++) begin
            if (k == 2) cordic_done = 1'b1;
            if (k == 3) cordic_done = 1'b0;
            #1;
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_angle", 32'(res_angle), 32'd59);
            check("bp_ready0",    32'(req0_ready), 32'd0);
            check("bp_ready1",    32'(req1_ready), 32'd0);
            step();
        end
        check("bp_res_id_held", 32'(res_id), 32'd0);
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        step();
        res_ready = 1'b0;
        #1;
        check("bp_released", 32'(res_valid), 32'd0);

        // Watchdog: requester 1 (rr now 1), engine never answers.
        req1_I     = 4'hE;
        req1_Q     = 4'd7;
        req1_valid = 1'b1;
        #1;
        check("to_ready1", 32'(req1_ready), 32'd1);
        check("to_ready0", 32'(req0_ready), 32'd0);
        step();
        req1_valid = 1'b0;
        #1;
        check("to_start",    32'(cordic_start), 32'd1);
        check("to_cordic_I", 32'(cordic_I), 32'hE);
        step();
        early = 1'b0;
        for (int k = 0; k < 63; k++) begin
            if (timeout_err !== 1'b0) early = 1'b1;
            step();
        end
        check("to_not_early", 32'(early), 32'd0);
        check("to_pulse",     32'(timeout_err), 32'd1);
        check("to_no_res",    32'(res_valid), 32'd0);
        step();
        check("to_pulse_end", 32'(timeout_err), 32'd0);
        cordic_done  = 1'b1;
        cordic_angle = 16'd123;
        step();
        cordic_done = 1'b0;
        #1;
        check("stray_res_valid", 32'(res_valid), 32'd0);
        check("stray_res_angle", 32'(res_angle), 32'd59);
        check("stray_start",     32'(cordic_start), 32'd0);
        check("stray_keep_I",    32'(cordic_I), 32'hE);

        // Done coinciding with the timeout cycle wins (rr now 0).
        req0_I     = 4'd1;
        req0_Q     = 4'hF;
        req0_valid = 1'b1;
        #1;
        check("dw_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        for (int k = 0; k < 63; k++) step();
        cordic_done  = 1'b1;
        cordic_angle = 16'hFFA6;
        #1;
        check("dw_no_timeout", 32'(timeout_err), 32'd0);
        step();
        cordic_done = 1'b0;
        #1;
        check("dw_res_valid", 32'(res_valid), 32'd1);
        check("dw_res_id",    32'(res_id), 32'd0);
        check("dw_res_angle", 32'(res_angle), 32'hFFA6);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Reset in WAIT, then a late done must not produce a result.
        req1_I     = 4'd2;
        req1_Q     = 4'd3;
        req1_valid = 1'b1;
        #1;
        check("r6_ready1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_all_zero("r6");
        step();
        reset_n = 1'b1;
        step();
        cordic_done  = 1'b1;
        cordic_angle = 16'd77;
        step();
        cordic_done = 1'b0;
        #1;
        check("r6_no_res", 32'(res_valid), 32'd0);

        // Round robin with both requesters always valid, starting at 0.
        req0_I     = 4'd1;
        req0_Q     = 4'd2;
        req1_I     = 4'hD;
        req1_Q     = 4'd4;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g     = i[0];
            exp_i = g ? 4'hD : 4'd1;
            exp_q = g ? 4'd4 : 4'd2;
            #1;
            check("rr_ready0", 32'(req0_ready), 32'(!g));
            check("rr_ready1", 32'(req1_ready), 32'(g));
            step();
            check("rr_start",    32'(cordic_start), 32'd1);
            check("rr_cordic_I", 32'(cordic_I), 32'(exp_i));
            check("rr_cordic_Q", 32'(cordic_Q), 32'(exp_q));
            step();
            cordic_done  = 1'b1;
            cordic_angle = 16'(100 + i);
            step();
            cordic_done = 1'b0;
            #1;
            check("rr_res_valid", 32'(res_valid), 32'd1);
            check("rr_res_id",    32'(res_id), 32'(g));
            check("rr_res_angle", 32'(res_angle), 32'(100 + i));
            check("rr_busy_rdy",  32'(req0_ready | req1_ready), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
